// File: rtl/capture_stop_gate.sv
`default_nettype none
// ============================================================================
// Module      : capture_stop_gate
// Description : Frame-aligned start/stop gate for a camera pixel stream.
//               A stop level from a software register is resynchronised and
//               applied only on frame boundaries. Capture starts at the next
//               start-of-frame and stops after the end-of-frame of the frame
//               in flight. Forwarded beats come out registered, one cycle
//               after they arrive.
//
// Parameters  : DATA_W          pixel data width
//               TIMEOUT_CYCLES  idle-beat watchdog limit (1..65535)
//
// Ports       : clk             system clock, rising edge
//               reset_n         asynchronous active-low reset
//               stop_in         stop request level (asynchronous to clk)
//               pix_*_in        camera beat: valid, sof, eof, data
//               pix_*_out       gated beat: valid, sof, eof, data
//               running         high while waiting for SOF or running
//               frame_count     complete frames forwarded (wraps at 16 bits)
//               stopped_pulse   one-cycle pulse on entry to STOPPED
//               timeout_flag    sticky watchdog abort indication
//
// Build option: CAPTURE_TIMEOUT_EN compiles in the idle-beat watchdog that
//               aborts a frame stalled while a stop is pending. Without it,
//               RUN is left only on an end-of-frame beat.
//
// Revision    : 1.0 - initial release
// ============================================================================
module capture_stop_gate #(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stop_in,
    input  logic              pix_valid_in,
    input  logic              pix_sof_in,
    input  logic              pix_eof_in,
    input  logic [DATA_W-1:0] pix_data_in,
    output logic              pix_valid_out,
    output logic              pix_sof_out,
    output logic              pix_eof_out,
    output logic [DATA_W-1:0] pix_data_out,
    output logic              running,
    output logic [15:0]       frame_count,
    output logic              stopped_pulse,
    output logic              timeout_flag
);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_forward;

    // Two-flop synchroniser. Both flops reset to 1 so the gate powers up
    // in the stop-requested condition.
    logic                r_stop_meta;
    logic                r_stop_sync;

    logic                r_valid_out;
    logic                r_sof_out;
    logic                r_eof_out;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_running;
    logic [15:0]         r_frame_count;
    logic                r_stopped_pulse;

`ifdef CAPTURE_TIMEOUT_EN
    localparam logic [15:0] c_wd_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0]         r_wd_cnt;
    logic                r_timeout_flag;
    logic                w_wd_count_en;
    logic                w_wd_fire;

    // The watchdog only guards a pending stop: an idle stream while capture
    // is meant to continue is legitimate inter-frame blanking.
    assign w_wd_count_en = (r_state == ST_RUN) && r_stop_sync && !pix_valid_in;
    assign w_wd_fire     = w_wd_count_en && (r_wd_cnt == c_wd_last);
`else
    logic                w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stop_meta <= 1'b1;
            r_stop_sync <= 1'b1;
        end else begin
            r_stop_meta <= stop_in;
            r_stop_sync <= r_stop_meta;
        end
    end

    // Next-state and forward decision.
    always_comb begin
        w_next_state = r_state;
        w_forward    = 1'b0;
        case (r_state)
            ST_STOPPED: begin
                if (!r_stop_sync) begin
                    w_next_state = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                // A SOF beat takes priority over a same-cycle stop so a frame
                // that has already begun is never cut off at its first beat.
                if (pix_valid_in && pix_sof_in) begin
                    w_forward = 1'b1;
                    if (pix_eof_in && r_stop_sync) begin
                        w_next_state = ST_STOPPED;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end else if (r_stop_sync) begin
                    w_next_state = ST_STOPPED;
                end
            end
            ST_RUN: begin
                if (pix_valid_in) begin
                    w_forward = 1'b1;
                    if (pix_eof_in && r_stop_sync) begin
                        w_next_state = ST_STOPPED;
                    end
                end
`ifdef CAPTURE_TIMEOUT_EN
                else if (w_wd_fire) begin
                    w_next_state = ST_STOPPED;
                end
`endif
            end
            default: begin
                w_next_state = ST_STOPPED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_STOPPED;
            r_valid_out     <= 1'b0;
            r_sof_out       <= 1'b0;
            r_eof_out       <= 1'b0;
            r_data_out      <= '0;
            r_running       <= 1'b0;
            r_frame_count   <= 16'd0;
            r_stopped_pulse <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
            r_wd_cnt        <= 16'd0;
            r_timeout_flag  <= 1'b0;
`endif
        end else begin
            r_state         <= w_next_state;
            r_running       <= (w_next_state != ST_STOPPED);
            // Reset lands directly in STOPPED without a transition, so the
            // pulse cannot fire after reset.
            r_stopped_pulse <= (w_next_state == ST_STOPPED) &&
                               (r_state != ST_STOPPED);

            // Qualifiers are zeroed for dropped beats; data holds its value.
            r_valid_out <= w_forward;
            r_sof_out   <= w_forward && pix_sof_in;
            r_eof_out   <= w_forward && pix_eof_in;
            if (w_forward) begin
                r_data_out <= pix_data_in;
            end

            if (w_forward && pix_eof_in) begin
                r_frame_count <= r_frame_count + 16'd1;
            end

`ifdef CAPTURE_TIMEOUT_EN
            if (w_wd_count_en && !w_wd_fire) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end else begin
                r_wd_cnt <= 16'd0;
            end

            if (w_wd_fire) begin
                r_timeout_flag <= 1'b1;
            end else if ((r_state == ST_STOPPED) &&
                         (w_next_state == ST_WAIT_SOF)) begin
                r_timeout_flag <= 1'b0;
            end
`endif
        end
    end

    assign pix_valid_out = r_valid_out;
    assign pix_sof_out   = r_sof_out;
    assign pix_eof_out   = r_eof_out;
    assign pix_data_out  = r_data_out;
    assign running       = r_running;
    assign frame_count   = r_frame_count;
    assign stopped_pulse = r_stopped_pulse;
`ifdef CAPTURE_TIMEOUT_EN
    assign timeout_flag  = r_timeout_flag;
`else
    assign timeout_flag  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_capture_stop_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_stop_gate
// Description : Self-checking bench for capture_stop_gate. Stimulus pushes
//               the expected forwarded beats into a queue; a monitor pops
//               and compares whenever pix_valid_out is high. Status outputs
//               are compared directly against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_stop_gate;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          stop_in;
    logic          v, sof, eof;
    logic [DW-1:0] din;

    logic          pix_valid_out, pix_sof_out, pix_eof_out;
    logic [DW-1:0] pix_data_out;
    logic          running;
    logic [15:0]   frame_count;
    logic          stopped_pulse;
    logic          timeout_flag;

    typedef struct packed {
        logic          sof;
        logic          eof;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    capture_stop_gate #(
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stop_in       (stop_in),
        .pix_valid_in  (v),
        .pix_sof_in    (sof),
        .pix_eof_in    (eof),
        .pix_data_in   (din),
        .pix_valid_out (pix_valid_out),
        .pix_sof_out   (pix_sof_out),
        .pix_eof_out   (pix_eof_out),
        .pix_data_out  (pix_data_out),
        .running       (running),
        .frame_count   (frame_count),
        .stopped_pulse (stopped_pulse),
        .timeout_flag  (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented beat must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        beat_t e;
        if (reset_n && pix_valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h expected=none", pix_data_out);
            end else begin
                e = exp_q.pop_front();
                chk("beat", 32'({pix_sof_out, pix_eof_out, pix_data_out}),
                    32'({e.sof, e.eof, e.data}));
            end
        end
    end

    // One input cycle; fwd says whether the gate must pass this beat.
    task automatic cyc(input logic vv, input logic ss, input logic ee,
                       input logic [DW-1:0] dd, input logic fwd);
        beat_t b;
        @(posedge clk);
        #1;
        v   = vv;
        sof = ss;
        eof = ee;
        din = dd;
        if (fwd) begin
            b.sof  = ss;
            b.eof  = ee;
            b.data = dd;
            exp_q.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    // Four-beat frame: sof on beat 0, eof on beat 3, optional repeated sof on beat 2.
    task automatic frame(input logic [DW-1:0] base, input logic fwd, input logic sof2);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, (i == 0) || (sof2 && (i == 2)), (i == 3), base + DW'(i), fwd);
        end
    endtask

    initial begin : stim
        int k;
        reset_n = 1'b0;
        stop_in = 1'b0;
        v = 1'b0; sof = 1'b0; eof = 1'b0; din = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",   32'(pix_valid_out), 32'd0);
        chk("rst_running", 32'(running),       32'd0);
        chk("rst_count",   32'(frame_count),   32'd0);
        chk("rst_pulse",   32'(stopped_pulse), 32'd0);
        chk("rst_timeout", 32'(timeout_flag),  32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // stop_in=0 after reset: reach WAIT_SOF, no pulse after reset
        idle(5);
        @(negedge clk);
        chk("start_running", 32'(running),       32'd1);
        chk("start_pulse",   32'(stopped_pulse), 32'd0);

        // Non-sof beats in WAIT_SOF are dropped
        cyc(1'b1, 1'b0, 1'b0, 16'hBAD0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'hBAD1, 1'b0);

        // Three frames forwarded; frame 3 has a repeated sof mid-frame
        frame(16'h1000, 1'b1, 1'b0);
        idle(1);
        frame(16'h2000, 1'b1, 1'b0);
        frame(16'h3000, 1'b1, 1'b1);
        idle(2);
        @(negedge clk);
        chk("three_frames_count", 32'(frame_count), 32'd3);
        chk("three_frames_run",   32'(running),     32'd1);

        // Stop requested at beat 1: frame completes, then STOPPED
        cyc(1'b1, 1'b1, 1'b0, 16'h4000, 1'b1);
        stop_in = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'h4001, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h4002, 1'b1);
        idle(2);
        cyc(1'b1, 1'b0, 1'b1, 16'h4003, 1'b1);
        idle(1);
        @(negedge clk);
        chk("stop_pulse",   32'(stopped_pulse), 32'd1);
        chk("stop_running", 32'(running),       32'd0);
        chk("stop_count",   32'(frame_count),   32'd4);
        idle(1);
        @(negedge clk);
        chk("stop_pulse_one_cycle", 32'(stopped_pulse), 32'd0);

        // Next frame fully dropped while stopped
        frame(16'h5000, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        chk("dropped_count", 32'(frame_count), 32'd4);

        // Restart, then single-beat frame arriving with stop_sync just asserted
        stop_in = 1'b0;
        idle(5);
        @(negedge clk);
        chk("restart_running", 32'(running), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 16'hBAD2, 1'b0);
        stop_in = 1'b1;
        idle(1);
        cyc(1'b1, 1'b1, 1'b1, 16'h6000, 1'b1);
        idle(1);
        @(negedge clk);
        chk("single_stop_pulse",   32'(stopped_pulse), 32'd1);
        chk("single_stop_running", 32'(running),       32'd0);
        chk("single_stop_count",   32'(frame_count),   32'd5);

        // Single-beat frame with stop released: forwarded, stays running
        stop_in = 1'b0;
        idle(5);
        cyc(1'b1, 1'b1, 1'b1, 16'h7000, 1'b1);
        idle(1);
        @(negedge clk);
        chk("single_run_running", 32'(running),       32'd1);
        chk("single_run_pulse",   32'(stopped_pulse), 32'd0);
        chk("single_run_count",   32'(frame_count),   32'd6);

        // frame_count wrap from a preset value
        @(negedge clk);
        force dut.r_frame_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_frame_count;
        chk("preset_count", 32'(frame_count), 32'h0000FFFE);
        cyc(1'b1, 1'b1, 1'b1, 16'h8000, 1'b1);
        idle(1);
        @(negedge clk);
        chk("count_ffff", 32'(frame_count), 32'h0000FFFF);
        cyc(1'b1, 1'b1, 1'b1, 16'h8001, 1'b1);
        idle(1);
        @(negedge clk);
        chk("count_wrap", 32'(frame_count), 32'h00000000);

        // Reset mid-frame, during beat 2: frame aborted, no eof emitted
        cyc(1'b1, 1'b1, 1'b0, 16'h9000, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h9001, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h9002, 1'b0);
        #5 reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid",   32'(pix_valid_out), 32'd0);
        chk("midrst_eof",     32'(pix_eof_out),   32'd0);
        chk("midrst_count",   32'(frame_count),   32'd0);
        chk("midrst_running", 32'(running),       32'd0);
        v = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 16'h9003, 1'b0);
        idle(5);
        @(negedge clk);
        chk("postrst_count",   32'(frame_count), 32'd0);
        chk("postrst_running", 32'(running),     32'd1);

        // Stalled frame with a pending stop
        cyc(1'b1, 1'b1, 1'b0, 16'hA000, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'hA001, 1'b1);
        stop_in = 1'b1;
        idle(1);
`ifdef CAPTURE_TIMEOUT_EN
        // 2 sync cycles + 8 idle cycles with stop_sync=1
        k = 31;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (stopped_pulse) begin
                k = n;
                break;
            end
        end
        chk("wd_latency",     32'(k),            32'd10);
        chk("wd_flag",        32'(timeout_flag), 32'd1);
        chk("wd_running",     32'(running),      32'd0);
        idle(3);
        @(negedge clk);
        chk("wd_flag_sticky", 32'(timeout_flag), 32'd1);
        stop_in = 1'b0;
        idle(5);
        @(negedge clk);
        chk("wd_flag_clear",  32'(timeout_flag), 32'd0);
        chk("wd_restart",     32'(running),      32'd1);
`else
        k = 0;
        idle(20);
        @(negedge clk);
        chk("stall_running", 32'(running),       32'd1);
        chk("stall_flag",    32'(timeout_flag),  32'd0);
        chk("stall_pulse",   32'(stopped_pulse), 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 16'hA002, 1'b1);
        idle(1);
        @(negedge clk);
        chk("stall_eof_pulse", 32'(stopped_pulse), 32'd1);
        chk("stall_count",     32'(frame_count),   32'd1);
`endif

        idle(3);
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : guard
        #50000;
        $display("FAIL time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
